parking_gate_arbiter: RTL
=========================

Name: parking_gate_arbiter

Overview:
Shares the single physical parking gate between an entry lane and an exit lane. It grants gate use to one lane at a time, tracks lot occupancy against a fixed capacity, and blocks entry when the lot is full. It sits above the per-lane gate/PIN controller: the arbiter's grant enables that controller, and the controller's completion pulse returns to the arbiter.

Parameters:
CAPACITY, 8, maximum vehicles in the lot (must be 1..2^CNT_W-1)
CNT_W, 4, width of occupancy counter
TIMEOUT, 32, cycles a grant may stay open without gate_done before abort

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
req_entry  input  1  entry lane request, level, held until served or withdrawn
req_exit  input  1  exit lane request, level, held until served or withdrawn
gate_done  input  1  one-cycle pulse from gate controller: vehicle passed, gate closed
grant_entry  output  1  entry lane owns the gate
grant_exit  output  1  exit lane owns the gate
occupancy  output  CNT_W  current vehicle count
lot_full  output  1  occupancy == CAPACITY
timeout_alarm  output  1  sticky; set when a grant aborts on timeout

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, grants 0, occupancy 0, lot_full 0, timeout_alarm 0, last_served=EXIT (so entry wins the first tie), timer 0.
- All outputs registered; grant asserts on the first rising edge after the qualifying request is sampled (1-cycle latency).
- Eligibility: entry_ok = req_entry & ~lot_full; exit_ok = req_exit & (occupancy != 0).
- States: IDLE, SERVE_ENTRY, SERVE_EXIT, ABORT.
- IDLE: if only entry_ok -> SERVE_ENTRY. If only exit_ok -> SERVE_EXIT. If both -> lane opposite last_served (round-robin). Otherwise stay. gate_done in IDLE is ignored.
- SERVE_x: grant_x=1, timer counts up from 0.
  - gate_done=1 -> occupancy +1 (entry) or -1 (exit); lot_full updated in the same edge; last_served=x; grant drops; next IDLE.
  - req_x withdrawn (0) without gate_done -> grant drops; no count change; next IDLE; last_served unchanged.
  - timer reaches TIMEOUT-1 without gate_done -> next ABORT; timeout_alarm=1.
  - gate_done has priority over withdrawal and timeout in the same cycle.
- ABORT: both grants 0; wait until the aborted lane's request is 0, then IDLE. timeout_alarm clears only on reset.
- Minimum one IDLE cycle between consecutive grants; the grants are never both 1.
- Counter saturates: no increment past CAPACITY, no decrement below 0 (unreachable through eligibility, but enforced).
- Full: while lot_full=1, req_entry is ignored; a pending exit is still served and clears lot_full on its gate_done edge.
- Reset mid-grant: grant drops immediately (asynchronous) and occupancy returns to 0.

Test Plan:
1. Reset, req_entry=1, gate_done pulse 3 cycles after grant -> grant_entry=1 one cycle after the request, occupancy 0->1, grant_entry=0 the cycle after done.
2. req_entry and req_exit both held with occupancy=2, done pulsed each grant -> grants alternate entry, exit, entry; occupancy 2->3->2->3; one IDLE cycle between grants.
3. Fill to 8 (CAPACITY), then req_entry=1 -> lot_full=1, grant_entry stays 0. Then req_exit plus done -> occupancy 7, lot_full=0, and entry is then granted.
4. Grant entry, no gate_done for 32 cycles -> grant_entry drops at cycle 32, timeout_alarm=1, occupancy unchanged. req_entry stays 1 -> no new grant until it is deasserted.
5. req_exit=1 with occupancy=0 -> no grant. req_entry withdrawn mid-grant -> grant drops, occupancy unchanged.
6. rst=0 asserted mid-SERVE_EXIT (occupancy=5) -> grant_exit=0 and occupancy=0 without a clock edge; timeout_alarm=0.

Source files
------------

// File: rtl/parking_gate_arbiter.sv
// Parking gate arbiter: shares one gate between entry and exit lanes,
// tracks lot occupancy and aborts grants that stall past a timeout.
module parking_gate_arbiter #(
    parameter int CAPACITY = 8,
    parameter int CNT_W    = 4,
    parameter int TIMEOUT  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_entry,
    input  logic             req_exit,
    input  logic             gate_done,
    output logic             grant_entry,
    output logic             grant_exit,
    output logic [CNT_W-1:0] occupancy,
    output logic             lot_full,
    output logic             timeout_alarm
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_ENTRY,
        SERVE_EXIT,
        ABORT
    } state_t;

    state_t           state;
    logic [TW-1:0]    timer;
    logic             last_exit;
    logic             abort_exit;
    logic             entry_ok;
    logic             exit_ok;
    logic             pick_entry;
    logic             abort_req;
    logic [CNT_W-1:0] occ_inc;
    logic [CNT_W-1:0] occ_dec;

    assign entry_ok   = req_entry & ~lot_full;
    assign exit_ok    = req_exit & (occupancy != '0);
    // On a tie the lane not served last wins
    assign pick_entry = entry_ok & (~exit_ok | last_exit);
    assign abort_req  = abort_exit ? req_exit : req_entry;

    assign occ_inc = (occupancy == CAP) ? occupancy
                                        : occupancy + CNT_W'(1);
    assign occ_dec = (occupancy == '0) ? occupancy
                                       : occupancy - CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            timer         <= '0;
            last_exit     <= 1'b1;
            abort_exit    <= 1'b0;
            grant_entry   <= 1'b0;
            grant_exit    <= 1'b0;
            occupancy     <= '0;
            lot_full      <= 1'b0;
            timeout_alarm <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    timer <= '0;
                    if (pick_entry) begin
                        state       <= SERVE_ENTRY;
                        grant_entry <= 1'b1;
                    end else if (exit_ok) begin
                        state      <= SERVE_EXIT;
                        grant_exit <= 1'b1;
                    end
                end
                SERVE_ENTRY: begin
                    if (gate_done) begin
                        occupancy   <= occ_inc;
                        lot_full    <= (occ_inc == CAP);
                        last_exit   <= 1'b0;
                        grant_entry <= 1'b0;
                        state       <= IDLE;
                    end else if (!req_entry) begin
                        grant_entry <= 1'b0;
                        state       <= IDLE;
                    end else if (timer == T_LAST) begin
                        grant_entry   <= 1'b0;
                        abort_exit    <= 1'b0;
                        timeout_alarm <= 1'b1;
                        state         <= ABORT;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                SERVE_EXIT: begin
                    if (gate_done) begin
                        occupancy  <= occ_dec;
                        lot_full   <= (occ_dec == CAP);
                        last_exit  <= 1'b1;
                        grant_exit <= 1'b0;
                        state      <= IDLE;
                    end else if (!req_exit) begin
                        grant_exit <= 1'b0;
                        state      <= IDLE;
                    end else if (timer == T_LAST) begin
                        grant_exit    <= 1'b0;
                        abort_exit    <= 1'b1;
                        timeout_alarm <= 1'b1;
                        state         <= ABORT;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ABORT: begin
                    if (!abort_req) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
